tug_field: RTL
==============

# tug_field

Playfield referee for the tug-of-war game. Turns raw left/right key levels into single press events, moves a one-hot light along the LED row, and detects when the light is pushed off either end. On a score it emits a one-cycle `win_l`/`win_r` pulse, which feeds the `victory` input of the per-player win counters. It then holds the field briefly and re-centres the light.

## Interface
- `NUM_LIGHTS`, 9: LED row length; must be odd and ≥ 3. Centre index is `(NUM_LIGHTS-1)/2`.
- `HOLDOFF_CYCLES`, 16: number of cycles the field is frozen after a score; must be ≥ 1.

Ports:
- `Clock` in 1: sole clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `key_l` in 1: raw left key level, asynchronous, 1 = pressed.
- `key_r` in 1: raw right key level, asynchronous, 1 = pressed.
- `leds` out `NUM_LIGHTS`: light position. Bit `NUM_LIGHTS-1` is the leftmost light and bit 0 the rightmost.
- `win_l` out 1: one-cycle pulse when the left player scores.
- `win_r` out 1: one-cycle pulse when the right player scores.
- `busy` out 1: high in SCORE and HOLD; key presses are ignored while it is high.

## Operation
- Each key goes through a 2-flop synchronizer, then a previous-value register.
  - Press event = synchronized value high and previous value low.
  - Synchronizer and previous registers reset to 1, so a key held through reset produces no event.
- `pos` register, width `$clog2(NUM_LIGHTS)`. `leds = 1 << pos` in PLAY.
- FSM states are PLAY, SCORE and HOLD. Reset state is PLAY with `pos` = centre.
- In PLAY:
  - `press_l` only: if `pos == NUM_LIGHTS-1`, go to SCORE with winner L and leave `pos` unchanged. Otherwise `pos <= pos+1`.
  - `press_r` only: if `pos == 0`, go to SCORE with winner R. Otherwise `pos <= pos-1`.
  - Both presses in the same cycle: no move and no score.
  - Neither press: hold.
- SCORE lasts exactly one cycle.
  - The winner's pulse is high and `leds` keeps the end light.
  - The winner register is latched on entry.
  - Next state is HOLD, with the hold counter loaded to `HOLDOFF_CYCLES-1`.
- HOLD:
  - `leds` shows the winner's end light steady.
  - The counter decrements each cycle.
  - When the counter is 0, next state is PLAY with `pos` = centre.
- Press events arriving in SCORE or HOLD are discarded, not queued. The edge registers keep tracking, so a key held across HOLD does not fire on the return to PLAY.
- Reset mid-SCORE or mid-HOLD: any pending pulse is dropped, and the block comes out in PLAY at centre with `win_*` = 0.

## Timing
- Reset values: `leds` = one-hot centre (`9'b000010000` for 9 lights), `win_l` = 0, `win_r` = 0, `busy` = 0.
- Key to move: `key_l` high at edge E0 → event valid between E1 and E2 → `leds` changes at E2.
- Key on the end light to win pulse: the pulse is high from E2 to E3, for exactly 1 cycle, and `busy` rises at E2.
- Score to play: SCORE takes 1 cycle and HOLD takes `HOLDOFF_CYCLES` cycles. `leds` returns to centre exactly `HOLDOFF_CYCLES+1` cycles after the pulse rises.
- `win_l` and `win_r` are never high together and are never high on consecutive cycles.

## Structure
- Shared package `tug_pkg` holds:
  - `typedef enum logic[1:0] {PLAY, SCORE, HOLD} field_state_t`.
  - `typedef enum logic {SIDE_L, SIDE_R} side_t`, also used by the scoreboard.
- One sub-module, `key_edge` (synchronizer plus rising-edge detector, reset to 1), instantiated once per key.
- `tug_field` itself contains the FSM, the position register, the hold counter and the output registers.
- Expected size is about 150–200 lines total.

## Test plan
All scenarios use `NUM_LIGHTS`=9 and `HOLDOFF_CYCLES`=4.
- Reset with `reset`=0 for 2 cycles → `leds`=`9'h010`, `win_l`=0, `win_r`=0, `busy`=0.
- Hold `key_l` high through reset, then release reset → no move. Release and re-press the key → `leds`=`9'h020` exactly 3 edges after the re-press is sampled.
- 4 separate `key_l` presses → `leds` steps `9'h020`, `9'h040`, `9'h080`, `9'h100`. A 5th press → `win_l` high for 1 cycle, then `leds` returns to `9'h010` 5 cycles after the pulse rises.
- Press both keys in the same cycle 3 times → `leds` stays `9'h010`, with no win pulse.
- From `pos`=0, press `key_r` → `win_r` pulses. Press `key_r` twice during HOLD → no pulse and no move; after HOLD, `leds`=`9'h010`.
- Drive `reset`=0 during HOLD → next cycle `leds`=`9'h010` and `busy`=0, with no further win pulse.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield: referee FSM states and player sides.
package tug_pkg;

  typedef enum logic [1:0] {PLAY, SCORE, HOLD} field_state_t;

  typedef enum logic {SIDE_L, SIDE_R} side_t;

  function automatic int centre_index(input int num_lights);
    return (num_lights - 1) / 2;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus rising-edge detector for one raw key level.
module key_edge (
  input  logic Clock,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Everything resets to 1 so a key already held when reset releases
  // looks like an old press rather than a new one.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and the three-stage shift behaves as a pipeline.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield referee: moves a one-hot light on key presses, detects a
// push off either end, pulses the winner, freezes the field, then re-centres.
module tug_field
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS     = 9,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  win_l,
  output logic                  win_r,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [PW-1:0] CENTRE = PW'(centre_index(NUM_LIGHTS));
  localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);

  logic press_l;
  logic press_r;

  key_edge u_edge_l (.Clock(Clock), .reset(reset), .key(key_l), .press(press_l));
  key_edge u_edge_r (.Clock(Clock), .reset(reset), .key(key_r), .press(press_r));

  field_state_t  state, state_next;
  logic [PW-1:0] pos, pos_next;
  side_t         winner, winner_next;
  logic [CW-1:0] cnt, cnt_next;

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state  <= PLAY;
      pos    <= CENTRE;
      winner <= SIDE_L;
      cnt    <= '0;
    end else begin
      state  <= state_next;
      pos    <= pos_next;
      winner <= winner_next;
      cnt    <= cnt_next;
    end
  end

  // NOTE: every variable gets its hold value before the case so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    pos_next    = pos;
    winner_next = winner;
    cnt_next    = cnt;
    case (state)
      PLAY: begin
        if (press_l && !press_r) begin
          if (pos == LAST) begin
            state_next  = SCORE;
            winner_next = SIDE_L;
          end else begin
            pos_next = pos + PW'(1);
          end
        end else if (press_r && !press_l) begin
          if (pos == '0) begin
            state_next  = SCORE;
            winner_next = SIDE_R;
          end else begin
            pos_next = pos - PW'(1);
          end
        end
      end
      SCORE: begin
        state_next = HOLD;
        cnt_next   = HOLD_LOAD;
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = PLAY;
          pos_next   = CENTRE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = PLAY;
        pos_next   = CENTRE;
      end
    endcase
  end

  // pos is left on the end light through SCORE and HOLD, so one decode
  // serves every state.
  assign leds  = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << pos;
  assign win_l = (state == SCORE) && (winner == SIDE_L);
  assign win_r = (state == SCORE) && (winner == SIDE_R);
  assign busy  = (state != PLAY);

endmodule
